// File: rtl/min_max_ctrl.sv
// Sequencing and configuration controller for the min/max LED bar display:
// power-on lamp test, validated command interface and blink oscillator.
module min_max_ctrl #(
    parameter int unsigned VALSIZE     = 4,
    parameter int unsigned OSC_DIV     = 8,
    parameter int unsigned TEST_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_sel_i,
    input  logic [VALSIZE-1:0] cmd_data_i,
    output logic               cmd_err_o,
    input  logic               test_i,
    output logic               busy_o,
    output logic [1:0]         com_o,
    output logic [VALSIZE-1:0] min_o,
    output logic [VALSIZE-1:0] max_o,
    output logic [VALSIZE-1:0] val_o,
    output logic               osc_o
);

    localparam int unsigned LW = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;
    localparam int unsigned OW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;
    localparam logic [LW-1:0] LAMP_LAST = LW'(TEST_CYCLES - 1);
    localparam logic [OW-1:0] OSC_LAST  = OW'(OSC_DIV - 1);

    typedef enum logic [1:0] {
        LAMP_ON,
        LAMP_OFF,
        RUN
    } state_t;

    state_t             state, state_nxt;
    logic [LW-1:0]      lamp_cnt, lamp_cnt_nxt;
    logic [OW-1:0]      osc_cnt;
    logic               osc;
    logic               mode;
    logic               err;
    logic [VALSIZE-1:0] min_r, max_r, val_r;
    logic               accept;
    logic               reject;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= LAMP_ON;
            lamp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lamp_cnt <= lamp_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lamp_cnt_nxt = lamp_cnt;
        case (state)
            LAMP_ON: begin
                if (lamp_cnt == LAMP_LAST) begin
                    state_nxt    = LAMP_OFF;
                    lamp_cnt_nxt = '0;
                end else begin
                    lamp_cnt_nxt = lamp_cnt + 1'b1;
                end
            end
            LAMP_OFF: begin
                if (lamp_cnt == LAMP_LAST) begin
                    state_nxt    = RUN;
                    lamp_cnt_nxt = '0;
                end else begin
                    lamp_cnt_nxt = lamp_cnt + 1'b1;
                end
            end
            RUN: begin
                lamp_cnt_nxt = '0;
                if (test_i) begin
                    state_nxt = LAMP_ON;
                end
            end
            default: begin
                state_nxt    = LAMP_ON;
                lamp_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        com_o       = 2'b11;
        busy_o      = 1'b1;
        cmd_ready_o = 1'b0;
        case (state)
            LAMP_ON:  com_o = 2'b11;
            LAMP_OFF: com_o = 2'b10;
            RUN: begin
                com_o       = {1'b0, mode};
                busy_o      = 1'b0;
                cmd_ready_o = 1'b1;
            end
            default: com_o = 2'b11;
        endcase
    end

    // Validation compares against the currently held bounds, keeping min < max.
    always_comb begin
        accept = cmd_valid_i && (state == RUN);
        reject = 1'b0;
        case (cmd_sel_i)
            2'b00:   reject = !(cmd_data_i < max_r);
            2'b01:   reject = !(cmd_data_i > min_r);
            default: reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_r <= '0;
            max_r <= '1;
            val_r <= '0;
            mode  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= accept && reject;
            if (accept && !reject) begin
                case (cmd_sel_i)
                    2'b00: min_r <= cmd_data_i;
                    2'b01: max_r <= cmd_data_i;
                    2'b10: val_r <= cmd_data_i;
                    2'b11: mode  <= cmd_data_i[0];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            osc_cnt <= '0;
            osc     <= 1'b0;
        end else if (osc_cnt == OSC_LAST) begin
            osc_cnt <= '0;
            osc     <= ~osc;
        end else begin
            osc_cnt <= osc_cnt + 1'b1;
        end
    end

    assign cmd_err_o = err;
    assign min_o     = min_r;
    assign max_o     = max_r;
    assign val_o     = val_r;
    assign osc_o     = osc;

endmodule
